// File: rtl/decoder_38_strobe.sv
// rtl/decoder_38_strobe.sv - 3-to-8 one-hot strobe decoder with hold/gap timing
// Optional even-parity check on the incoming code: DECODER_38_STROBE_PARITY_EN
module decoder_38_strobe #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in,
  input  logic       in_par,
  output logic [7:0] out,
  output logic       busy,
  output logic       done,
  output logic       par_err
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       out_n;
  logic             busy_n, done_n, par_err_n;
  logic             xfer, par_bad;

  assign in_ready = en && (state == IDLE);
  assign xfer     = in_valid && in_ready;

`ifdef DECODER_38_STROBE_PARITY_EN
  assign par_bad = ^{in, in_par};
`else
  logic unused_par;
  assign unused_par = in_par;
  assign par_bad    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      out     <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      par_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      out     <= out_n;
      busy    <= busy_n;
      done    <= done_n;
      par_err <= par_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    out_n     = out;
    busy_n    = busy;
    done_n    = 1'b0;
    par_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (par_bad) begin
            par_err_n = 1'b1;
          end else begin
            state_n = HOLD;
            out_n   = 8'h01 << in;
            cnt_n   = HOLD_INIT;
            busy_n  = 1'b1;
          end
        end
      end
      HOLD: begin
        // abort wins over a completion landing in the same cycle
        if (!en) begin
          state_n = IDLE;
          out_n   = 8'h00;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          out_n  = 8'h00;
          done_n = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            state_n = GAP;
            cnt_n   = GAP_INIT;
          end
        end
      end
      GAP: begin
        out_n = 8'h00;
        if (!en || cnt == '0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = 8'h00;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_38_strobe.sv
// tb/tb_decoder_38_strobe.sv - directed self-checking bench for decoder_38_strobe
module tb_decoder_38_strobe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, in_valid = 1'b0, in_par = 1'b0;
  logic [2:0] in = 3'd0;
  logic       in_ready, busy, done, par_err;
  logic [7:0] out;

  logic       en1 = 1'b0, in_valid1 = 1'b0;
  logic [2:0] in1 = 3'd0;
  logic       in_ready1, busy1, done1, par_err1;
  logic [7:0] out1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] oh_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  always #5 clk = ~clk;

  decoder_38_strobe dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in(in), .in_par(in_par), .out(out), .busy(busy), .done(done), .par_err(par_err)
  );

  decoder_38_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in(in1), .in_par(1'b0), .out(out1), .busy(busy1), .done(done1), .par_err(par_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_out", out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_par_err", par_err, 1'b0);
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    en1 = 1'b1;
    tick();

    // async reset in the middle of HOLD
    in_valid = 1'b1; in = 3'd5;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midhold_out", out, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 8'h00);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1'b1);

    // sweep of all codes, back-to-back
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in = 3'(c);
      chk($sformatf("sweep%0d_ready", c), in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("sweep%0d_out_c1", c), out, oh_tab[c]);
      chk($sformatf("sweep%0d_busy", c), busy, 1'b1);
      chk($sformatf("sweep%0d_ready_hold", c), in_ready, 1'b0);
      for (int k = 2; k <= 4; k++) begin
        tick();
        chk($sformatf("sweep%0d_out_c%0d", c, k), out, oh_tab[c]);
        chk($sformatf("sweep%0d_nodone_c%0d", c, k), done, 1'b0);
      end
      tick();
      chk($sformatf("sweep%0d_gap_out", c), out, 8'h00);
      chk($sformatf("sweep%0d_done", c), done, 1'b1);
      chk($sformatf("sweep%0d_gap_busy", c), busy, 1'b1);
      chk($sformatf("sweep%0d_gap_ready", c), in_ready, 1'b0);
      tick();
      chk($sformatf("sweep%0d_done_clr", c), done, 1'b0);
      chk($sformatf("sweep%0d_idle_busy", c), busy, 1'b0);
    end

    // enable gating
    en = 1'b0; in_valid = 1'b1; in = 3'd5;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("gate_ready_%0d", k), in_ready, 1'b0);
      chk($sformatf("gate_out_%0d", k), out, 8'h00);
    end
    en = 1'b1;
    #1;
    chk("gate_ready_en", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("gate_out_after", out, 8'h20);
    repeat (5) tick();
    chk("gate_back_idle", in_ready, 1'b1);

    // abort on the 2nd HOLD cycle
    in_valid = 1'b1; in = 3'd2;
    tick();
    in_valid = 1'b0;
    chk("abort_hold1", out, 8'h04);
    tick();
    chk("abort_hold2", out, 8'h04);
    en = 1'b0;
    tick();
    chk("abort_out", out, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    tick();
    chk("abort_done_later", done, 1'b0);
    en = 1'b1;
    #1;
    chk("abort_ready", in_ready, 1'b1);
    tick();

    // HOLD_CYCLES=1, GAP_CYCLES=0
    in_valid1 = 1'b1; in1 = 3'd7;
    tick();
    in_valid1 = 1'b0;
    chk("p1_out", out1, 8'h80);
    chk("p1_ready_hold", in_ready1, 1'b0);
    tick();
    chk("p1_out_off", out1, 8'h00);
    chk("p1_done", done1, 1'b1);
    chk("p1_busy", busy1, 1'b0);
    chk("p1_ready", in_ready1, 1'b1);
    tick();
    chk("p1_done_clr", done1, 1'b0);
    chk("p1_par_err", par_err1, 1'b0);

    // parity handling
    in_valid = 1'b1; in = 3'd3; in_par = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef DECODER_38_STROBE_PARITY_EN
    chk("par_bad_err", par_err, 1'b1);
    chk("par_bad_out", out, 8'h00);
    chk("par_bad_busy", busy, 1'b0);
    chk("par_bad_ready", in_ready, 1'b1);
    tick();
    chk("par_err_clr", par_err, 1'b0);
`else
    chk("par_off_err", par_err, 1'b0);
    chk("par_off_out", out, 8'h08);
    repeat (5) tick();
    chk("par_off_err_end", par_err, 1'b0);
`endif
    in_valid = 1'b1; in = 3'd3; in_par = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("par_good_out", out, 8'h08);
    chk("par_good_err", par_err, 1'b0);
    repeat (6) tick();
    chk("final_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
